// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and default sizes for the sweep sequencer.
//   state_t      : sequencer FSM states (IDLE, UP, DOWN)
//   DEF_WIDTH    : default counter / bound width
//   DEF_SWEEPS_W : default width of the sweep-count field
package sweep_pkg;

    localparam int DEF_WIDTH    = 3;
    localparam int DEF_SWEEPS_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/sweep_counter.sv
// sweep_counter: loadable up/down counter datapath.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   load       : count <= data_in (wins over enable)
//   up_dn      : 1 = increment, 0 = decrement when enabled
//   enable     : advance the count by one this edge
//   data_in    : load value
//   count      : registered counter value
module sweep_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             up_dn,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= data_in;
        else if (enable)
            count <= up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
    end

endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: sequences a loadable up/down counter through n lo->hi->lo sweeps
// on a single start request.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   start        : one-cycle request, only looked at in IDLE
//   lo, hi       : sweep bounds, captured on an accepted start
//   n_sweeps     : number of sweeps, captured on an accepted start
//   hold         : freezes the run while busy
//   abort        : ends a run early (only when SWEEP_ABORT_EN is defined)
//   count        : counter value
//   dir          : 1 while counting up
//   busy         : high from start acceptance to completion
//   done         : one-cycle pulse after the completing edge
//   err          : one-cycle pulse after a rejected start
// Build option: SWEEP_ABORT_EN adds the abort input.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SWEEPS_W = DEF_SWEEPS_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    lo,
    input  logic [WIDTH-1:0]    hi,
    input  logic [SWEEPS_W-1:0] n_sweeps,
    input  logic                hold,
`ifdef SWEEP_ABORT_EN
    input  logic                abort,
`endif
    output logic [WIDTH-1:0]    count,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    lo_q, hi_q;
    logic [SWEEPS_W-1:0] n_q;
    logic [SWEEPS_W-1:0] sweep_q, sweep_d;
    logic                done_d, err_d;
    logic                capture;
    logic                cnt_load, cnt_up, cnt_en;
    logic                abort_i;

`ifdef SWEEP_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    sweep_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .up_dn   (cnt_up),
        .enable  (cnt_en),
        .data_in (lo),
        .count   (count)
    );

    // Turnaround compares look one step ahead (hi-1 / lo+1) so the edge that
    // writes the bound is also the edge that changes state. lo<hi is
    // guaranteed while busy, so neither expression can wrap.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        capture  = 1'b0;
        cnt_load = 1'b0;
        cnt_up   = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort_i) begin
                    if (lo >= hi || n_sweeps == '0) begin
                        err_d = 1'b1;
                    end else begin
                        capture  = 1'b1;
                        cnt_load = 1'b1;
                        sweep_d  = '0;
                        state_d  = UP;
                    end
                end
            end
            UP: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b1;
                    if (count == hi_q - WIDTH'(1))
                        state_d = DOWN;
                end
            end
            DOWN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    cnt_en = 1'b1;
                    if (count == lo_q + WIDTH'(1)) begin
                        sweep_d = sweep_q + SWEEPS_W'(1);
                        if (sweep_q + SWEEPS_W'(1) == n_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = UP;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sweep_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            n_q     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            done    <= done_d;
            err     <= err_d;
            if (capture) begin
                lo_q <= lo;
                hi_q <= hi;
                n_q  <= n_sweeps;
            end
        end
    end

    // dir and busy are decoded from the state register, so they stay registered.
    assign dir  = (state_q == UP);
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed and randomized checks of sweep_ctrl against a
// trajectory-queue model. On an accepted start the model lays out every
// (count, dir) value the run must produce; each non-held busy edge pops one.
// Build option: SWEEP_ABORT_EN exercises the abort input.
module tb_sweep_ctrl;

    localparam int W  = 3;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset, start, hold, abort;
    logic [W-1:0]  lo, hi;
    logic [SW-1:0] n_sweeps;
    logic [W-1:0]  count;
    logic          dir, busy, done, err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int m_count, m_dir, m_busy, m_done, m_err;
    int q_cnt[$];
    int q_dir[$];

    always #5 clk = ~clk;

    sweep_ctrl #(.WIDTH(W), .SWEEPS_W(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .lo       (lo),
        .hi       (hi),
        .n_sweeps (n_sweeps),
        .hold     (hold),
`ifdef SWEEP_ABORT_EN
        .abort    (abort),
`endif
        .count    (count),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_dir = 0; m_busy = 0; m_done = 0; m_err = 0;
        q_cnt.delete();
        q_dir.delete();
    endtask

    // Every value written after the load edge, in order.
    task automatic build(input int l, input int h, input int n);
        for (int s = 0; s < n; s++) begin
            for (int v = l + 1; v <= h; v++) begin
                q_cnt.push_back(v);
                q_dir.push_back(v == h ? 0 : 1);
            end
            for (int v = h - 1; v >= l; v--) begin
                q_cnt.push_back(v);
                q_dir.push_back((v == l && s != n - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic model_edge();
        m_done = 0;
        m_err  = 0;
        if (m_busy != 0) begin
            if (abort) begin
                m_busy = 0;
                m_dir  = 0;
                q_cnt.delete();
                q_dir.delete();
            end else if (!hold) begin
                m_count = q_cnt.pop_front();
                m_dir   = q_dir.pop_front();
                if (q_cnt.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (!abort && start) begin
            if (int'(lo) >= int'(hi) || n_sweeps == 0) begin
                m_err = 1;
            end else begin
                m_count = lo;
                m_dir   = 1;
                m_busy  = 1;
                build(lo, hi, n_sweeps);
            end
        end
    endtask

    task automatic check_model();
        tests++;
        if (int'(count) != m_count || int'(dir) != m_dir || int'(busy) != m_busy ||
            int'(done) != m_done || int'(err) != m_err) begin
            fails++;
            $display("FAIL model cycle %0d: got count=%0d dir=%0d busy=%0d done=%0d err=%0d, expected count=%0d dir=%0d busy=%0d done=%0d err=%0d",
                     cyc, count, dir, busy, done, err, m_count, m_dir, m_busy, m_done, m_err);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        cyc++;
    endtask

    task automatic go(input int l, input int h, input int n);
        lo = W'(l); hi = W'(h); n_sweeps = SW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int exp_basic[13] = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
    int e, held, ok;

    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
        lo = '0; hi = '0; n_sweeps = '0;
        model_reset();
        #3;
        chk("reset_count", count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_dir", dir, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Basic run lo=2 hi=5 n=2
        go(2, 5, 2);
        chk("basic_e0", count, exp_basic[0]);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("basic_e%0d", i), count, exp_basic[i]);
            chk($sformatf("basic_done_e%0d", i), done, (i == 12) ? 1 : 0);
        end
        chk("basic_end_busy", busy, 0);
        chk("basic_end_dir", dir, 0);
        tick();
        chk("basic_done_gone", done, 0);

        // Rejected starts: count must stay at 2
        go(5, 5, 1);
        chk("rej_eq_err", err, 1);
        chk("rej_eq_busy", busy, 0);
        chk("rej_eq_count", count, 2);
        tick();
        chk("rej_eq_err_pulse", err, 0);
        go(6, 2, 1);
        chk("rej_inv_err", err, 1);
        chk("rej_inv_count", count, 2);
        tick();
        go(1, 4, 0);
        chk("rej_n0_err", err, 1);
        chk("rej_n0_busy", busy, 0);
        tick();
        chk("rej_n0_err_pulse", err, 0);

        // Hold at count=4 going up, mid-run start, changing bounds inputs
        go(0, 7, 1);
        e = 0; held = 0; ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (m_count == 4 && m_dir == 1 && held < 3) begin
                hold = 1'b1;
                held++;
            end else begin
                hold = 1'b0;
            end
            start    = (e == 10);
            lo       = W'($urandom_range(0, 7));
            hi       = W'($urandom_range(0, 7));
            n_sweeps = SW'($urandom_range(0, 15));
            tick();
            e++;
            if (hold) chk("hold_count", count, 4);
            if (done) begin
                ok = 1;
                chk("hold_done_edge", e, 17);
                chk("hold_done_count", count, 0);
            end
        end
        hold = 1'b0; start = 1'b0;
        chk("hold_done_seen", ok, 1);

        // Asynchronous reset mid-DOWN
        go(1, 6, 1);
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (m_busy != 0 && m_dir == 0 && m_count == 4) ok = 1;
        end
        chk("rst_reached_down", ok, 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        check_model();
        #1;
        reset = 1'b0;
        go(3, 4, 3);
        e = 0; ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            e++;
            if (done) ok = 1;
        end
        chk("post_rst_done_edge", e, 6);
        chk("post_rst_count", count, 3);

`ifdef SWEEP_ABORT_EN
        go(0, 7, 2);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (m_count == 3 && m_dir == 1) ok = 1;
            else tick();
        end
        chk("abort_reached", ok, 1);
        abort = 1'b1; hold = 1'b1;
        tick();
        abort = 1'b0; hold = 1'b0;
        chk("abort_count", count, 3);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_no_done", done, 0);
        abort = 1'b1;
        go(1, 0, 1);
        chk("abort_start_inv_err", err, 0);
        go(1, 5, 1);
        chk("abort_start_busy", busy, 0);
        abort = 1'b0;
        tick();
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            start    = ($urandom_range(0, 5) == 0);
            lo       = W'($urandom_range(0, 7));
            hi       = W'($urandom_range(0, 7));
            n_sweeps = SW'($urandom_range(0, 3));
            hold     = ($urandom_range(0, 3) == 0);
`ifdef SWEEP_ABORT_EN
            abort    = ($urandom_range(0, 40) == 0);
`endif
            tick();
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
